// File: rtl/bus_arbiter_rr_pkg.sv
// Shared definitions for the round-robin bus arbiter: state encodings,
// grant/reset polarity constants and the master-count ceiling.
package bus_arbiter_rr_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    localparam int   BUS_MASTERS_MAX = 16;
    localparam int   TENURE_W        = 8;

    localparam logic ENABLE_         = 1'b0;
    localparam logic DISABLE_        = 1'b1;
    localparam logic RESET_ENABLE    = 1'b1;
    localparam logic RESET_DISABLE   = 1'b0;

    // Next index after idx in a ring of n masters.
    function automatic logic [3:0] wrap_inc(input logic [3:0] idx, input int n);
        logic [3:0] nxt;
        nxt = (int'(idx) == n - 1) ? 4'd0 : idx + 4'd1;
        return nxt;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin search: first active request at or after start,
// wrapping; with excl set the final wrap candidate (the current owner) is skipped.
module bus_arbiter_rr_picker #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    input  logic         excl,
    output logic         found,
    output logic [W-1:0] pick
);

    logic [W:0] idx;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = {1'b0, start} + (W+1)'(i);
            if (idx >= (W+1)'(N)) begin
                idx = idx - (W+1)'(N);
            end
            if (!found && req[idx[W-1:0]] && !(excl && i == N - 1)) begin
                found = 1'b1;
                pick  = idx[W-1:0];
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter with registered active-low one-cold grant.
// Optional tenure limit built when BUS_ARBITER_TIMEOUT_EN is defined.
//
//   state    | meaning
//   ---------+---------------------------------------------
//   ST_IDLE  | no grant, grnt_ all ones, busy low
//   ST_GRANT | one master owns the bus, owner/grnt_ valid
module bus_arbiter_rr
    import bus_arbiter_rr_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int OWNER_W     = $clog2(NUM_MASTERS),
    parameter int MAX_TENURE  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] req_,
    output logic [NUM_MASTERS-1:0] grnt_,
    output logic [OWNER_W-1:0]     owner,
    output logic                   busy
);

    if (NUM_MASTERS < 2 || NUM_MASTERS > BUS_MASTERS_MAX ||
        MAX_TENURE < 2 || MAX_TENURE > 256) begin : g_bad_param
        $error("bus_arbiter_rr: parameter out of range");
    end

    arb_state_t             state_q, state_d;
    logic [OWNER_W-1:0]     owner_q, owner_d;
    logic [OWNER_W-1:0]     last_q, last_d;
    logic [NUM_MASTERS-1:0] grnt_q, grnt_d;
    logic [NUM_MASTERS-1:0] req;
    logic [OWNER_W-1:0]     start;
    logic                   excl;
    logic                   found;
    logic [OWNER_W-1:0]     pick;
    logic                   take;

    assign req   = ~req_;
    assign start = OWNER_W'(wrap_inc(4'(last_q), NUM_MASTERS));
    // last_q equals the owner while granted, so the owner is the final wrap candidate.
    assign excl  = (state_q == ST_GRANT);

    bus_arbiter_rr_picker #(
        .N (NUM_MASTERS),
        .W (OWNER_W)
    ) u_rr_picker (
        .req   (req),
        .start (start),
        .excl  (excl),
        .found (found),
        .pick  (pick)
    );

`ifdef BUS_ARBITER_TIMEOUT_EN
    // Down-counter: cycles of tenure left before a waiting master may take over.
    localparam logic [TENURE_W-1:0] TEN_LOAD = TENURE_W'(MAX_TENURE - 1);
    logic [TENURE_W-1:0] ten_q, ten_d;
    logic                ten_tc;
    assign ten_tc = (ten_q == '0);
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        grnt_d  = grnt_q;
        take    = 1'b0;
`ifdef BUS_ARBITER_TIMEOUT_EN
        ten_d   = ten_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (found) take = 1'b1;
            end
            ST_GRANT: begin
                if (!req[owner_q]) begin
                    if (found) begin
                        take = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        grnt_d  = {NUM_MASTERS{DISABLE_}};
                    end
                end
`ifdef BUS_ARBITER_TIMEOUT_EN
                else if (ten_tc) begin
                    if (found) take = 1'b1;
                end else begin
                    ten_d = ten_q - 1'b1;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
                grnt_d  = {NUM_MASTERS{DISABLE_}};
            end
        endcase
        if (take) begin
            state_d      = ST_GRANT;
            owner_d      = pick;
            last_d       = pick;
            grnt_d       = {NUM_MASTERS{DISABLE_}};
            grnt_d[pick] = ENABLE_;
`ifdef BUS_ARBITER_TIMEOUT_EN
            ten_d        = TEN_LOAD;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset == RESET_ENABLE) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            last_q  <= OWNER_W'(NUM_MASTERS - 1);
            grnt_q  <= {NUM_MASTERS{DISABLE_}};
`ifdef BUS_ARBITER_TIMEOUT_EN
            ten_q   <= TEN_LOAD;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            grnt_q  <= grnt_d;
`ifdef BUS_ARBITER_TIMEOUT_EN
            ten_q   <= ten_d;
`endif
        end
    end

    assign grnt_ = grnt_q;
    assign owner = owner_q;
    assign busy  = ~&grnt_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr (4 masters, tenure limit 4) against
// a behavioural round-robin model; follows BUS_ARBITER_TIMEOUT_EN like the DUT.
module tb_bus_arbiter_rr;

    localparam int NM = 4;
    localparam int MT = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NM-1:0] req_ = '1;
    logic [NM-1:0] grnt_;
    logic [1:0]    owner;
    logic          busy;

    int n_total = 0;
    int n_bad   = 0;

    bit m_busy  = 1'b0;
    int m_owner = 0;
    int m_last  = NM - 1;
    int m_ten   = 0;

    bus_arbiter_rr #(
        .NUM_MASTERS (NM),
        .MAX_TENURE  (MT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req_  (req_),
        .grnt_ (grnt_),
        .owner (owner),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Next requesting master after 'last' around the ring, never 'skip'; -1 if none.
    function automatic int rr_next(input int last, input logic [NM-1:0] rq, input int skip);
        for (int k = 1; k <= NM; k++) begin
            int c;
            c = (last + k) % NM;
            if (c != skip && rq[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_edge(input bit rst, input logic [NM-1:0] rq);
        int p;
        if (rst) begin
            m_busy = 1'b0; m_owner = 0; m_last = NM - 1; m_ten = 0;
        end else if (!m_busy) begin
            p = rr_next(m_last, rq, -1);
            if (p >= 0) begin
                m_busy = 1'b1; m_owner = p; m_last = p; m_ten = 0;
            end
        end else if (!rq[m_owner]) begin
            p = rr_next(m_last, rq, m_owner);
            if (p >= 0) begin
                m_owner = p; m_last = p; m_ten = 0;
            end else begin
                m_busy = 1'b0;
            end
        end else begin
            p = rr_next(m_last, rq, m_owner);
`ifdef BUS_ARBITER_TIMEOUT_EN
            if (m_ten == MT - 1 && p >= 0) begin
                m_owner = p; m_last = p; m_ten = 0;
            end else if (m_ten < MT - 1) begin
                m_ten++;
            end
`endif
        end
    endtask

    function automatic logic [NM-1:0] exp_grnt();
        logic [NM-1:0] g;
        g = '1;
        if (m_busy) g[m_owner] = 1'b0;
        return g;
    endfunction

    task automatic step(input bit rst, input logic [NM-1:0] rq_n);
        @(negedge clk);
        reset = rst;
        req_  = rq_n;
        @(posedge clk);
        model_edge(rst, ~rq_n);
        #1;
        chk("grnt_", 32'(grnt_), 32'(exp_grnt()));
        chk("busy", 32'(busy), 32'(m_busy));
        if (m_busy) chk("owner", 32'(owner), 32'(m_owner));
    endtask

    initial begin
        logic [NM-1:0] rq_n;

        step(1, 4'b1111);
        step(1, 4'b1111);
        chk("reset_grnt", 32'(grnt_), 32'h0000_000f);
        chk("reset_owner", 32'(owner), 32'd0);
        step(0, 4'b1110);
        chk("first_grant", 32'(grnt_), 32'h0000_000e);

        step(0, 4'b1100);
        step(0, 4'b1101);
        chk("handoff_no_gap", 32'(grnt_), 32'h0000_000d);

        step(1, 4'b1111);
        step(0, 4'b0000);
        chk("rr_first", 32'(owner), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            rq_n = 4'b0000;
            rq_n[(k - 1) % 4] = 1'b1;
            step(0, rq_n);
            chk("rr_order", 32'(owner), 32'(k % 4));
        end

        step(1, 4'b1111);
        step(0, 4'b1011);
        for (int k = 0; k < 4; k++) step(0, 4'b0011);
`ifdef BUS_ARBITER_TIMEOUT_EN
        chk("timeout_owner", 32'(owner), 32'd3);
        chk("timeout_grnt", 32'(grnt_), 32'h0000_0007);
`else
        chk("timeout_owner", 32'(owner), 32'd2);
        chk("timeout_grnt", 32'(grnt_), 32'h0000_000b);
`endif
        for (int k = 0; k < 6; k++) step(0, 4'b0011);

        step(1, 4'b1111);
        for (int k = 0; k < 10; k++) begin
            step(0, 4'b1101);
            chk("sole_busy", 32'(busy), 32'd1);
        end

        step(1, 4'b1111);
        step(0, 4'b0111);
        step(0, 4'b0111);
        step(1, 4'b0111);
        chk("reset_mid_grnt", 32'(grnt_), 32'h0000_000f);
        step(0, 4'b0110);
        chk("post_reset_owner", 32'(owner), 32'd0);
        chk("post_reset_grnt", 32'(grnt_), 32'h0000_000e);

        rq_n = 4'b1111;
        for (int k = 0; k < 500; k++) begin
            rq_n = rq_n ^ NM'($urandom & $urandom);
            step(($urandom_range(0, 63) == 0), rq_n);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
